// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: EX forwarding selects,
// load-use stall sequencing, branch flush and saturating perf counters.
module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32,
   parameter int LOAD_STALL = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rt,
   input  logic [REG_ADDR_W-1:0] ex_rs,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  mem_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic                  wb_reg_write,
   input  logic                  mem_pc_src,
   input  logic                  wb_valid,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  id_ex_bubble,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  ex_mem_flush,
   output logic                  stall_state,
   output logic [CNT_W-1:0]      cycle_cnt,
   output logic [CNT_W-1:0]      retire_cnt,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   localparam logic [0:0] RUN      = 1'b0;
   localparam logic [0:0] LU_STALL = 1'b1;

   logic [0:0] state, state_nx;
   logic [3:0] remain, remain_nx;
   logic       lu, stall, flush;
   logic       mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;

   // Operand forwarding; the younger EX/MEM result wins over MEM/WB
   always_comb begin
      mem_hit_a = mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs);
      mem_hit_b = mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rt);
      wb_hit_a  = wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs);
      wb_hit_b  = wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rt);
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (!rst) begin
         if (mem_hit_a)     fwd_a = 2'b10;
         else if (wb_hit_a) fwd_a = 2'b01;
         if (mem_hit_b)     fwd_b = 2'b10;
         else if (wb_hit_b) fwd_b = 2'b01;
      end
   end

   // Load-use detection, stall/flush outputs and next-state selection
   always_comb begin
      lu = ex_mem_read && (ex_rd != '0) &&
           ((id_uses_rs && (ex_rd == id_rs)) ||
            (id_uses_rt && (ex_rd == id_rt)));
      flush = !rst && mem_pc_src;
      stall = !rst && !mem_pc_src &&
              ((state == LU_STALL) || lu);
      pc_write     = !stall;
      if_id_write  = !stall;
      id_ex_bubble = stall;
      if_id_flush  = flush;
      id_ex_flush  = flush;
      ex_mem_flush = flush;
      stall_state  = (state == LU_STALL);
      state_nx  = state;
      remain_nx = remain;
      if (mem_pc_src) begin
         state_nx  = RUN;
         remain_nx = 4'd0;
      end else if (state == RUN) begin
         if (lu && (LOAD_STALL > 1)) begin
            state_nx  = LU_STALL;
            remain_nx = 4'(LOAD_STALL - 1);
         end
      end else begin
         if (remain <= 4'd1) begin
            state_nx  = RUN;
            remain_nx = 4'd0;
         end else begin
            remain_nx = remain - 4'd1;
         end
      end
   end

   // FSM state and remaining-stall register
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= RUN;
         remain <= 4'd0;
      end else begin
         state  <= state_nx;
         remain <= remain_nx;
      end
   end

   // Saturating performance counters
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt  <= '0;
         retire_cnt <= '0;
         stall_cnt  <= '0;
         flush_cnt  <= '0;
      end else begin
         if (cycle_cnt != '1)
            cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (wb_valid && (retire_cnt != '1))
            retire_cnt <= retire_cnt + CNT_W'(1);
         if (!pc_write && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (mem_pc_src && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (1-cycle and 3-cycle
// load stall, the latter with 4-bit counters) against a reference model.
module tb_pipeline_hazard_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
   logic       id_uses_rs, id_uses_rt, ex_mem_read;
   logic       mem_reg_write, wb_reg_write, mem_pc_src, wb_valid;

   logic [1:0]  fa0, fb0, fa1, fb1;
   logic        pcw0, ifw0, bub0, iff0, idf0, exf0, ss0;
   logic        pcw1, ifw1, bub1, iff1, idf1, exf1, ss1;
   logic [31:0] cc0, rc0, sc0, fc0;
   logic [3:0]  cc1, rc1, sc1, fc1;

   pipeline_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32), .LOAD_STALL(1)) u_ls1 (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .mem_rd(mem_rd),
      .mem_reg_write(mem_reg_write), .wb_rd(wb_rd),
      .wb_reg_write(wb_reg_write), .mem_pc_src(mem_pc_src),
      .wb_valid(wb_valid), .fwd_a(fa0), .fwd_b(fb0),
      .pc_write(pcw0), .if_id_write(ifw0), .id_ex_bubble(bub0),
      .if_id_flush(iff0), .id_ex_flush(idf0), .ex_mem_flush(exf0),
      .stall_state(ss0), .cycle_cnt(cc0), .retire_cnt(rc0),
      .stall_cnt(sc0), .flush_cnt(fc0));

   pipeline_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(4), .LOAD_STALL(3)) u_ls3 (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .mem_rd(mem_rd),
      .mem_reg_write(mem_reg_write), .wb_rd(wb_rd),
      .wb_reg_write(wb_reg_write), .mem_pc_src(mem_pc_src),
      .wb_valid(wb_valid), .fwd_a(fa1), .fwd_b(fb1),
      .pc_write(pcw1), .if_id_write(ifw1), .id_ex_bubble(bub1),
      .if_id_flush(iff1), .id_ex_flush(idf1), .ex_mem_flush(exf1),
      .stall_state(ss1), .cycle_cnt(cc1), .retire_cnt(rc1),
      .stall_cnt(sc1), .flush_cnt(fc1));

   int n_vec = 0;
   int n_bad = 0;

   // reference state: stall cycles still owed after the current one
   int     left [2];
   longint m_cyc [2], m_ret [2], m_stl [2], m_fl [2];
   int     ls [2] = '{1, 3};
   longint mx [2] = '{64'hFFFF_FFFF, 64'd15};

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] ref_fwd(input logic [4:0] src);
      if (rst) return 2'b00;
      if (mem_reg_write && mem_rd != 0 && mem_rd == src) return 2'b10;
      if (wb_reg_write && wb_rd != 0 && wb_rd == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic longint sat(input longint v, input longint m,
                                  input bit inc);
      if (inc && v < m) return v + 1;
      return v;
   endfunction

   task automatic set_idle();
      id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0;
      mem_rd = 0; wb_rd = 0; id_uses_rs = 0; id_uses_rt = 0;
      ex_mem_read = 0; mem_reg_write = 0; wb_reg_write = 0;
      mem_pc_src = 0; wb_valid = 0;
   endtask

   task automatic set_lu();
      ex_mem_read = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1;
   endtask

   // one clock: check counters and outputs mid-cycle, then advance model
   task automatic cyc();
      bit lu, stl [2], fl;
      @(negedge clk);
      #1;
      chk("cyc0", cc0, m_cyc[0]);  chk("ret0", rc0, m_ret[0]);
      chk("stl0", sc0, m_stl[0]);  chk("fl0", fc0, m_fl[0]);
      chk("cyc1", cc1, m_cyc[1]);  chk("ret1", rc1, m_ret[1]);
      chk("stl1", sc1, m_stl[1]);  chk("fl1", fc1, m_fl[1]);
      chk("fwd_a", {fa0, fa1}, {ref_fwd(ex_rs), ref_fwd(ex_rs)});
      chk("fwd_b", {fb0, fb1}, {ref_fwd(ex_rt), ref_fwd(ex_rt)});
      lu = ex_mem_read && ex_rd != 0 &&
           ((id_uses_rs && ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));
      fl = !rst && mem_pc_src;
      for (int i = 0; i < 2; i++)
         stl[i] = !rst && !mem_pc_src && (left[i] > 0 || lu);
      chk("ctl0", {pcw0, ifw0, bub0, iff0, idf0, exf0},
          {!stl[0], !stl[0], stl[0], fl, fl, fl});
      chk("ctl1", {pcw1, ifw1, bub1, iff1, idf1, exf1},
          {!stl[1], !stl[1], stl[1], fl, fl, fl});
      if (!rst) chk("sstate", {ss0, ss1}, {left[0] > 0, left[1] > 0});
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            left[i] = 0;
            m_cyc[i] = 0; m_ret[i] = 0; m_stl[i] = 0; m_fl[i] = 0;
         end else begin
            m_cyc[i] = sat(m_cyc[i], mx[i], 1'b1);
            m_ret[i] = sat(m_ret[i], mx[i], wb_valid);
            m_stl[i] = sat(m_stl[i], mx[i], stl[i]);
            m_fl[i]  = sat(m_fl[i], mx[i], mem_pc_src);
            if (mem_pc_src)      left[i] = 0;
            else if (left[i] > 0) left[i] = left[i] - 1;
            else if (lu)          left[i] = ls[i] - 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1; set_idle(); cyc(); rst = 0;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         left[i] = 0; m_cyc[i] = 0; m_ret[i] = 0; m_stl[i] = 0; m_fl[i] = 0;
      end
      set_idle();
      rst = 1;
      @(posedge clk); #1;
      cyc();
      chk("rst_pcw", {pcw0, pcw1, ifw1}, 3'b111);
      rst = 0;

      mem_rd = 3; mem_reg_write = 1; wb_rd = 3; wb_reg_write = 1;
      ex_rs = 3; ex_rt = 4;
      cyc();
      chk("fwd_mem", {fa0, fb0}, 4'b1000);
      mem_reg_write = 0;
      cyc();
      chk("fwd_wb", fa0, 2'b01);
      mem_rd = 0; ex_rs = 0;
      cyc();
      chk("fwd_r0", fa0, 2'b00);

      do_reset();
      set_lu(); cyc();
      set_idle();
      for (int k = 0; k < 4; k++) cyc();
      chk("lu_cnt1", sc0, 32'd1);
      chk("lu_cnt3", sc1, 4'd3);

      do_reset();
      set_lu(); cyc();
      set_idle(); mem_pc_src = 1; cyc();
      mem_pc_src = 0; cyc(); cyc();
      chk("br_stl", sc1, 4'd1);
      chk("br_fl", fc1, 4'd1);
      chk("br_ss", ss1, 1'b0);

      do_reset();
      wb_valid = 1;
      for (int k = 0; k < 20; k++) cyc();
      chk("sat_cyc", cc1, 4'd15);
      chk("sat_ret", rc1, 4'd15);
      wb_valid = 0;
      set_lu(); cyc();
      set_idle(); cyc();
      rst = 1; cyc(); rst = 0;
      chk("rst_cnt", {cc1, rc1, sc1, fc1}, 16'h0);
      chk("rst_ss", ss1, 1'b0);
      chk("rst_pc", pcw1, 1'b1);

      for (int k = 0; k < 400; k++) begin
         rst = ($urandom_range(0, 49) == 0);
         id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
         ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
         ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
         wb_rd = 5'($urandom_range(0, 3));
         id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
         ex_mem_read = ($urandom_range(0, 2) == 0);
         mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
         mem_pc_src = ($urandom_range(0, 7) == 0);
         wb_valid = 1'($urandom);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Produces EX-stage operand forwarding selects.
- Detects load-use hazards and stalls the front end for a parametrised number of cycles.
- Flushes younger stages on a taken branch resolved in MEM, and keeps saturating performance counters (cycles, retired, stall, flush) that the pipeline top exposes for trace/debug.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- CNT_W, 32, width of each performance counter.
- LOAD_STALL, 1, bubbles inserted per load-use hazard (1..15); values >1 model multi-cycle data memory.

Ports:
- clk  input  1  pipeline clock, rising-edge.
- rst  input  1  synchronous active-high reset.
- id_rs, id_rt  input  REG_ADDR_W  source regs of instruction in IF/ID.
- id_uses_rs, id_uses_rt  input  1  ID instruction actually reads rs / rt.
- ex_rs, ex_rt  input  REG_ADDR_W  source regs of instruction in ID/EX.
- ex_rd  input  REG_ADDR_W  destination (post RegDest mux) in ID/EX.
- ex_mem_read  input  1  ID/EX.MemRead.
- mem_rd  input  REG_ADDR_W  EX/MEM.rd.
- mem_reg_write  input  1  EX/MEM.RegWrite.
- wb_rd  input  REG_ADDR_W  MEM/WB.rd.
- wb_reg_write  input  1  MEM/WB.RegWrite.
- mem_pc_src  input  1  taken branch resolved in MEM (pcSrc).
- wb_valid  input  1  non-bubble instruction in WB this cycle.
- fwd_a, fwd_b  output  2  ALU operand A/B select: 00 = reg file, 10 = EX/MEM.aluresult, 01 = MEM/WB result.
- pc_write  output  1  PC may update.
- if_id_write  output  1  IF/ID may load.
- id_ex_bubble  output  1  zero ID/EX control bits.
- if_id_flush, id_ex_flush, ex_mem_flush  output  1  clear the register's control/valid bits.
- stall_state  output  1  FSM in LU_STALL.
- cycle_cnt, retire_cnt, stall_cnt, flush_cnt  output  CNT_W  performance counters.

Behaviour:
- Reset (sync, rst high at posedge) forces:
  - FSM to RUN, stall counter to 0.
  - All four counters to 0.
  - While rst is high, outputs read: pc_write = 1, if_id_write = 1, all flush/bubble = 0, fwd = 00.
  - A stall or flush in progress is abandoned.
- Forwarding (combinational, zero latency), shown for A; B is identical using ex_rt:
  - fwd_a = 10 if mem_reg_write && mem_rd != 0 && mem_rd == ex_rs.
  - else 01 if wb_reg_write && wb_rd != 0 && wb_rd == ex_rs.
  - else 00.
  - EX/MEM has priority when both match.
- Load-use detect (combinational): lu = ex_mem_read && ex_rd != 0 && ((id_uses_rs && ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt)).
- FSM:
  - RUN:
    - If lu && !mem_pc_src: stall outputs (pc_write = 0, if_id_write = 0, id_ex_bubble = 1) this cycle.
    - If LOAD_STALL > 1, go to LU_STALL with remaining = LOAD_STALL-1; otherwise stay in RUN.
  - LU_STALL:
    - Stall outputs asserted every cycle; remaining decrements each cycle.
    - When remaining reaches 1, return to RUN at the next edge.
    - Total stall cycles per hazard = LOAD_STALL exactly.
    - lu is not re-evaluated while in LU_STALL.
- Branch flush:
  - When mem_pc_src = 1, if_id_flush, id_ex_flush and ex_mem_flush are asserted the same cycle.
  - pc_write = 1 and if_id_write = 1 so the target is fetched.
  - Flush overrides a simultaneous lu and aborts LU_STALL (next state RUN, no stall outputs that cycle).
- Counters, updated on each non-reset edge; all saturate at 2^CNT_W-1 with no wrap:
  - cycle_cnt increments every cycle.
  - retire_cnt increments when wb_valid = 1.
  - stall_cnt increments on each cycle with pc_write = 0.
  - flush_cnt increments on each cycle with mem_pc_src = 1.
- Register 0 never forwards and never triggers a stall.

Test Plan:
- Forwarding: mem_rd = 3/mem_reg_write = 1, wb_rd = 3/wb_reg_write = 1, ex_rs = 3, ex_rt = 4 -> fwd_a = 10, fwd_b = 00; drop mem_reg_write -> fwd_a = 01; set mem_rd = 0, ex_rs = 0 -> fwd_a = 00.
- Load-use, LOAD_STALL = 1: ex_mem_read = 1, ex_rd = 5, id_rs = 5, id_uses_rs = 1 for one cycle -> exactly one cycle of pc_write = 0/id_ex_bubble = 1; stall_cnt = 1.
- Load-use, LOAD_STALL = 3: same stimulus -> 3 consecutive stall cycles, stall_state high for cycles 2-3, then RUN; stall_cnt = 3.
- Branch during stall (LOAD_STALL = 3): assert mem_pc_src in stall cycle 2 -> that cycle has all flushes = 1 and pc_write = 1, FSM returns to RUN; stall_cnt = 1, flush_cnt = 1.
- Saturation/reset: CNT_W = 4, run 20 cycles with wb_valid = 1 -> cycle_cnt = retire_cnt = 15; assert rst mid-LU_STALL -> next edge all counters 0, stall_state = 0, pc_write = 1.
